// File: rtl/hazard_pkg.sv
// hazard_pkg: shared select codes, shadow-stage tag type and tag match helper
package hazard_pkg;
  localparam int REG_W = 5;
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } stage_tag_t;
  // x0 is hardwired zero, so nothing ever "writes" it for hazard purposes.
  function automatic logic tag_writes(input stage_tag_t t, input logic [REG_W-1:0] r);
    return t.valid && t.reg_write && t.rd == r && r != '0;
  endfunction
endpackage

// File: rtl/fwd_select.sv
// fwd_select: forwarding mux select for one source operand
//   src, uses        source index and whether the instruction reads it
//   ex_tag, mem_tag  shadow tags of the instructions now in EX and MEM
//   sel              FWD_MEM if EX producer matches, else FWD_WB if MEM producer matches, else FWD_NONE
module fwd_select
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             uses,
  input  stage_tag_t       ex_tag,
  input  stage_tag_t       mem_tag,
  output logic [1:0]       sel
);
  always_comb sel = !uses ? FWD_NONE :
                    tag_writes(ex_tag, src) ? FWD_MEM :
                    tag_writes(mem_tag, src) ? FWD_WB : FWD_NONE;
endmodule

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: forwarding selects, load-use stall and branch flush for the 5-stage core
//   clk, rst          core clock, synchronous active-high reset
//   pipe_hold         global freeze: tags and registered selects hold
//   id_*              decoded fields of the instruction in ID
//   ex_branch_taken   branch/jump resolved taken in EX
//   fwd_a_sel/b_sel   registered mux selects for the instruction now in EX
//   stall_if_id, bubble_id_ex, flush_if_id  combinational pipeline controls
//   HAZARD_PERF_CNT_EN adds saturating perf_stall_cnt, perf_flush_cnt, perf_fwd_cnt
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pipe_hold,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             ex_branch_taken,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt,
  output logic [31:0]      perf_fwd_cnt,
`endif
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall_if_id,
  output logic             bubble_id_ex,
  output logic             flush_if_id
);
  // The WB-stage tag is never consulted: a producer in WB has already written
  // the register file by the time the consumer in ID reads it, so the shadow
  // pipe only needs to track EX and MEM.
  stage_tag_t ex_tag_q, ex_tag_d, mem_tag_q, mem_tag_d, id_tag;
  logic [1:0] fwd_a_sel_q, fwd_a_sel_d, fwd_b_sel_q, fwd_b_sel_d, sel_a, sel_b;
  logic       load_use;
  assign id_tag = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};
  fwd_select u_sel_a (.src(id_rs1), .uses(id_uses_rs1), .ex_tag(ex_tag_q), .mem_tag(mem_tag_q), .sel(sel_a));
  fwd_select u_sel_b (.src(id_rs2), .uses(id_uses_rs2), .ex_tag(ex_tag_q), .mem_tag(mem_tag_q), .sel(sel_b));
  always_comb begin
    load_use     = !rst && id_valid && ex_tag_q.mem_read &&
                   ((id_uses_rs1 && tag_writes(ex_tag_q, id_rs1)) ||
                    (id_uses_rs2 && tag_writes(ex_tag_q, id_rs2)));
    flush_if_id  = !rst && ex_branch_taken;
    stall_if_id  = load_use && !ex_branch_taken;
    bubble_id_ex = load_use || flush_if_id;
    ex_tag_d     = pipe_hold ? ex_tag_q : (bubble_id_ex || !id_valid) ? '0 : id_tag;
    mem_tag_d    = pipe_hold ? mem_tag_q : ex_tag_q;
    fwd_a_sel_d  = pipe_hold ? fwd_a_sel_q : bubble_id_ex ? FWD_NONE : sel_a;
    fwd_b_sel_d  = pipe_hold ? fwd_b_sel_q : bubble_id_ex ? FWD_NONE : sel_b;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_tag_q    <= '0;
      mem_tag_q   <= '0;
      fwd_a_sel_q <= FWD_NONE;
      fwd_b_sel_q <= FWD_NONE;
    end else begin
      ex_tag_q    <= ex_tag_d;
      mem_tag_q   <= mem_tag_d;
      fwd_a_sel_q <= fwd_a_sel_d;
      fwd_b_sel_q <= fwd_b_sel_d;
    end
  end
  assign fwd_a_sel = fwd_a_sel_q;
  assign fwd_b_sel = fwd_b_sel_q;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d, perf_flush_cnt_q, perf_flush_cnt_d;
  logic [31:0] perf_fwd_cnt_q, perf_fwd_cnt_d;
  logic [1:0]  fwd_inc;
  function automatic logic [31:0] sat_add(input logic [31:0] c, input logic [1:0] inc);
    logic [32:0] s;
    s = {1'b0, c} + {31'b0, inc};
    return s[32] ? '1 : s[31:0];
  endfunction
  always_comb begin
    fwd_inc          = {1'b0, |fwd_a_sel_d} + {1'b0, |fwd_b_sel_d};
    perf_stall_cnt_d = pipe_hold ? perf_stall_cnt_q : sat_add(perf_stall_cnt_q, {1'b0, stall_if_id});
    perf_flush_cnt_d = pipe_hold ? perf_flush_cnt_q : sat_add(perf_flush_cnt_q, {1'b0, flush_if_id});
    perf_fwd_cnt_d   = pipe_hold ? perf_fwd_cnt_q : sat_add(perf_fwd_cnt_q, fwd_inc);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt_q <= '0;
      perf_flush_cnt_q <= '0;
      perf_fwd_cnt_q   <= '0;
    end else begin
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
      perf_fwd_cnt_q   <= perf_fwd_cnt_d;
    end
  end
  assign perf_stall_cnt = perf_stall_cnt_q;
  assign perf_flush_cnt = perf_flush_cnt_q;
  assign perf_fwd_cnt   = perf_fwd_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl: scoreboard bench for hazard_forward_ctrl
module tb_hazard_forward_ctrl;
  logic       clk = 1'b0;
  logic       rst, pipe_hold, id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read, ex_branch_taken;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall_if_id, bubble_id_ex, flush_if_id;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_fwd_cnt;
`endif
  always #5 clk = ~clk;
  hazard_forward_ctrl dut (
    .clk(clk), .rst(rst), .pipe_hold(pipe_hold), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken),
`ifdef HAZARD_PERF_CNT_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt), .perf_fwd_cnt(perf_fwd_cnt),
`endif
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id)
  );
  typedef struct packed {logic v; logic [4:0] rd; logic rw; logic mr;} mtag_t;
  mtag_t      m_ex, m_mem;
  logic [1:0] m_a, m_b;
  logic [3:0] sb[$];
  logic       got_stall, got_bub, got_flush;
  int         n_checks = 0, n_err = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic writes(input mtag_t t, input logic [4:0] r);
    return t.v && t.rw && t.rd == r && r != 5'd0;
  endfunction
  function automatic logic [1:0] src_sel(input logic u, input logic [4:0] r);
    return !u ? 2'd0 : writes(m_ex, r) ? 2'd1 : writes(m_mem, r) ? 2'd2 : 2'd0;
  endfunction
  task automatic step(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                      input logic u2, input logic [4:0] rd, input logic rw, input logic mr,
                      input logic br, input logic hold, input logic r);
    logic lu, e_flush, e_stall, e_bub;
    logic [1:0] ea, eb;
    logic [3:0] exp;
    rst = r; pipe_hold = hold; id_valid = v; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2;
    id_uses_rs2 = u2; id_rd = rd; id_reg_write = rw; id_mem_read = mr; ex_branch_taken = br;
    lu = !r && v && m_ex.v && m_ex.mr && ((u1 && writes(m_ex, rs1)) || (u2 && writes(m_ex, rs2)));
    e_flush = !r && br;
    e_stall = lu && !br;
    e_bub   = lu || e_flush;
    ea = r ? 2'd0 : hold ? m_a : e_bub ? 2'd0 : src_sel(u1, rs1);
    eb = r ? 2'd0 : hold ? m_b : e_bub ? 2'd0 : src_sel(u2, rs2);
    sb.push_back({ea, eb});
    #1;
    got_stall = stall_if_id; got_bub = bubble_id_ex; got_flush = flush_if_id;
    check("stall_if_id", got_stall, e_stall);
    check("bubble_id_ex", got_bub, e_bub);
    check("flush_if_id", got_flush, e_flush);
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    check("fwd_a_sel", fwd_a_sel, exp[3:2]);
    check("fwd_b_sel", fwd_b_sel, exp[1:0]);
    m_a = ea; m_b = eb;
    if (r) begin
      m_ex = '0; m_mem = '0;
    end else if (!hold) begin
      m_mem = m_ex;
      m_ex  = (e_bub || !v) ? '0 : {1'b1, rd, rw, mr};
    end
  endtask
  task automatic alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic br, input logic hold);
    step(1, rs1, 1, rs2, 1, rd, 1, 0, br, hold, 0);
  endtask
  task automatic ld(input logic [4:0] rd, input logic [4:0] rs1);
    step(1, rs1, 1, 5'd0, 0, rd, 1, 1, 0, 0, 0);
  endtask
  task automatic nop();
    step(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
  endtask
  task automatic reset_step();
    step(1, 5'd3, 1, 5'd3, 1, 5'd3, 1, 1, 1, 0, 1);
  endtask
  initial begin
    m_ex = '0; m_mem = '0; m_a = 2'd0; m_b = 2'd0;
    @(negedge clk);
    reset_step();
    reset_step();
    check("rst_flush_gated", got_flush, 0);
    check("rst_sel_a", fwd_a_sel, 0);
    // back-to-back dependency
    alu(5, 1, 2, 0, 0);
    alu(6, 5, 1, 0, 0);
    check("b2b_sel_a", fwd_a_sel, 1);
    check("b2b_no_stall", got_stall, 0);
    // dependency two back
    alu(5, 3, 4, 0, 0);
    nop();
    alu(7, 2, 5, 0, 0);
    check("two_back_sel_b", fwd_b_sel, 2);
    check("two_back_sel_a", fwd_a_sel, 0);
    // load-use: one stall, then WB-path forward
    ld(8, 1);
    alu(9, 8, 8, 0, 0);
    check("lu_stall", got_stall, 1);
    check("lu_bubble", got_bub, 1);
    check("lu_bubble_sel", fwd_a_sel, 0);
    alu(9, 8, 8, 0, 0);
    check("lu_once", got_stall, 0);
    check("lu_after_a", fwd_a_sel, 2);
    check("lu_after_b", fwd_b_sel, 2);
    // x0 never forwards or stalls
    ld(0, 1);
    alu(3, 0, 0, 0, 0);
    check("x0_ld_stall", got_stall, 0);
    check("x0_ld_sel", fwd_a_sel, 0);
    alu(0, 1, 2, 0, 0);
    alu(3, 0, 0, 0, 0);
    check("x0_alu_sel", fwd_b_sel, 0);
    // flush beats load-use
    ld(8, 1);
    alu(9, 8, 2, 1, 0);
    check("fl_flush", got_flush, 1);
    check("fl_no_stall", got_stall, 0);
    check("fl_bubble", got_bub, 1);
    check("fl_sel", fwd_a_sel, 0);
    // reset mid-stream discards tags
    alu(12, 1, 2, 0, 0);
    reset_step();
    check("mid_rst_a", fwd_a_sel, 0);
    alu(13, 12, 12, 0, 0);
    check("post_rst_a", fwd_a_sel, 0);
    check("post_rst_b", fwd_b_sel, 0);
    // hold during a pending MEM forward
    alu(14, 1, 2, 0, 0);
    alu(15, 14, 1, 0, 0);
    check("hold_pre", fwd_a_sel, 1);
    for (int i = 0; i < 3; i++) begin
      alu(20, 15, 15, 0, 1);
      check("hold_sel", fwd_a_sel, 1);
    end
    alu(16, 14, 15, 0, 0);
    check("hold_tag_a", fwd_a_sel, 2);
    check("hold_tag_b", fwd_b_sel, 1);
    // random traffic on a small register window
    for (int i = 0; i < 120; i++)
      step($urandom_range(0, 7) != 0, 5'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 5)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 29) == 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
